// File: rtl/timer_pkg.sv
// Shared types for the multi-mode timer.
//   timer_mode_t  : start-mode encoding as seen on i_mode
//   timer_state_t : controller state encoding
package timer_pkg;

    localparam int MODE_W  = 2;
    localparam int STATE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_SHORT  = 2'd0,
        MODE_LONG   = 2'd1,
        MODE_CUSTOM = 2'd2,
        MODE_RSVD   = 2'd3
    } timer_mode_t;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } timer_state_t;

endpackage

// File: rtl/timer_down_cnt.sv
// Loadable down-counter.
//   clk, rst   : clock, synchronous active-high reset (count -> 0)
//   load       : load load_val (has priority over en)
//   load_val   : value loaded
//   en         : decrement by one; holds at zero
//   cnt        : current count
//   zero       : cnt == 0
module timer_down_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             zero
);

    assign zero = (cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && !zero) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/multi_mode_timer.sv
// Multi-mode timer: counts SHORT_LEN, LONG_LEN or a run-time custom length,
// with busy / almost-done / done-pulse / sticky-done status and abort.
// Optional feature macro: MULTI_MODE_TIMER_PAUSE_EN adds i_pause, which
// freezes a run in progress.
//   clk, rst      : clock, synchronous active-high reset
//   i_pause       : (only with MULTI_MODE_TIMER_PAUSE_EN) hold the run
//   i_start       : start request
//   i_mode        : 0=SHORT, 1=LONG, 2=CUSTOM, 3=reserved (rejected)
//   i_custom_len  : custom length, sampled on the accept edge (0 acts as 1)
//   i_abort       : cancel a run / clear completed status
//   o_busy        : run in progress
//   almost_done   : run in progress and remaining count < ALMOST_MARGIN
//   done_FSM      : one-cycle completion pulse
//   done_counter  : sticky completion status
//   o_err         : one-cycle pulse on a rejected start
//   o_count       : remaining count
module multi_mode_timer
    import timer_pkg::*;
#(
    parameter int CNT_W         = 8,
    parameter int SHORT_LEN     = 16,
    parameter int LONG_LEN      = 64,
    parameter int ALMOST_MARGIN = 4
) (
    input  logic             clk,
    input  logic             rst,
`ifdef MULTI_MODE_TIMER_PAUSE_EN
    input  logic             i_pause,
`endif
    input  logic             i_start,
    input  logic [1:0]       i_mode,
    input  logic [CNT_W-1:0] i_custom_len,
    input  logic             i_abort,
    output logic             o_busy,
    output logic             almost_done,
    output logic             done_FSM,
    output logic             done_counter,
    output logic             o_err,
    output logic [CNT_W-1:0] o_count
);

    // Counter is loaded with len-1 so that the done edge is the len-th edge.
    localparam logic [CNT_W-1:0] SHORT_LOAD = CNT_W'(SHORT_LEN - 1);
    localparam logic [CNT_W-1:0] LONG_LOAD  = CNT_W'(LONG_LEN - 1);
    localparam logic [CNT_W:0]   ALMOST_THR = (CNT_W+1)'(ALMOST_MARGIN);

    timer_state_t     state_q, state_d;
    timer_mode_t      mode;
    logic             pause;
    logic             load, en, cnt_zero;
    logic [CNT_W-1:0] load_val, start_load, cnt;
    logic             done_fsm_d, done_cnt_d, err_d;

    assign mode = timer_mode_t'(i_mode);

`ifdef MULTI_MODE_TIMER_PAUSE_EN
    assign pause = i_pause;
`else
    assign pause = 1'b0;
`endif

    always_comb begin
        start_load = '0;
        case (mode)
            MODE_SHORT:  start_load = SHORT_LOAD;
            MODE_LONG:   start_load = LONG_LOAD;
            MODE_CUSTOM: start_load = (i_custom_len == '0) ? '0 : i_custom_len - CNT_W'(1);
            default:     start_load = '0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        load       = 1'b0;
        load_val   = '0;
        en         = 1'b0;
        done_fsm_d = 1'b0;
        done_cnt_d = done_counter;
        err_d      = 1'b0;
        case (state_q)
            RUN: begin
                if (i_abort) begin
                    state_d  = IDLE;
                    load     = 1'b1;
                    load_val = '0;
                end else if (!pause) begin
                    if (cnt_zero) begin
                        state_d    = DONE;
                        done_fsm_d = 1'b1;
                        done_cnt_d = 1'b1;
                    end else begin
                        en = 1'b1;
                    end
                end
            end
            // IDLE and DONE accept starts identically; unknown codes recover here too.
            default: begin
                if (i_abort) begin
                    state_d    = IDLE;
                    done_cnt_d = 1'b0;
                end else if (i_start) begin
                    if (mode == MODE_RSVD) begin
                        err_d = 1'b1;
                    end else begin
                        state_d    = RUN;
                        load       = 1'b1;
                        load_val   = start_load;
                        done_cnt_d = 1'b0;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            done_FSM     <= 1'b0;
            done_counter <= 1'b0;
            o_err        <= 1'b0;
        end else begin
            state_q      <= state_d;
            done_FSM     <= done_fsm_d;
            done_counter <= done_cnt_d;
            o_err        <= err_d;
        end
    end

    timer_down_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .en       (en),
        .cnt      (cnt),
        .zero     (cnt_zero)
    );

    // Status decoded from registered state/count only.
    assign o_busy      = (state_q == RUN);
    assign almost_done = (state_q == RUN) && ({1'b0, cnt} < ALMOST_THR);
    assign o_count     = cnt;

endmodule

// File: tb/tb_multi_mode_timer.sv
// Self-checking bench for multi_mode_timer: directed scenarios plus a
// randomized phase, every cycle compared against a behavioural model.
module tb_multi_mode_timer;

`ifdef MULTI_MODE_TIMER_PAUSE_EN
    localparam bit PAUSE_EN = 1'b1;
`else
    localparam bit PAUSE_EN = 1'b0;
`endif

    localparam int EV_NONE  = 0;
    localparam int EV_START = 1;
    localparam int EV_ABORT = 2;
    localparam int EV_RST   = 3;
    localparam int EV_PAUSE = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pause_s = 1'b0;
    logic       i_start = 1'b0;
    logic [1:0] i_mode = 2'd0;
    logic [7:0] i_custom_len = 8'd0;
    logic       i_abort = 1'b0;
    logic       o_busy, almost_done, done_FSM, done_counter, o_err;
    logic [7:0] o_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: phase 0=idle 1=running 2=finished, rem = cycles left.
    int m_phase = 0;
    int m_rem   = 0;
    bit m_dfsm  = 0;
    bit m_dcnt  = 0;
    bit m_err   = 0;

    always #5 clk = ~clk;

    multi_mode_timer dut (
        .clk          (clk),
        .rst          (rst),
`ifdef MULTI_MODE_TIMER_PAUSE_EN
        .i_pause      (pause_s),
`endif
        .i_start      (i_start),
        .i_mode       (i_mode),
        .i_custom_len (i_custom_len),
        .i_abort      (i_abort),
        .o_busy       (o_busy),
        .almost_done  (almost_done),
        .done_FSM     (done_FSM),
        .done_counter (done_counter),
        .o_err        (o_err),
        .o_count      (o_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic model_step(input bit r, input bit st, input logic [1:0] md,
                              input logic [7:0] cl, input bit ab, input bit pz);
        int len;
        if (r) begin
            m_phase = 0; m_rem = 0; m_dfsm = 0; m_dcnt = 0; m_err = 0;
            return;
        end
        m_dfsm = 0;
        m_err  = 0;
        if (m_phase == 1) begin
            if (ab) begin
                m_phase = 0; m_rem = 0;
            end else if (!(pz && PAUSE_EN)) begin
                if (m_rem == 0) begin
                    m_phase = 2; m_dfsm = 1; m_dcnt = 1;
                end else begin
                    m_rem = m_rem - 1;
                end
            end
        end else if (ab) begin
            m_phase = 0; m_dcnt = 0;
        end else if (st) begin
            if (md == 2'd3) begin
                m_err = 1;
            end else begin
                len = (md == 2'd0) ? 16 : (md == 2'd1) ? 64 : ((cl == 0) ? 1 : int'(cl));
                m_rem = len - 1; m_phase = 1; m_dcnt = 0;
            end
        end
    endtask

    task automatic cyc(input bit r, input bit st, input logic [1:0] md,
                       input logic [7:0] cl, input bit ab, input bit pz);
        rst = r; i_start = st; i_mode = md; i_custom_len = cl; i_abort = ab; pause_s = pz;
        @(posedge clk);
        model_step(r, st, md, cl, ab, pz);
        #1;
        chk("busy",   o_busy,       (m_phase == 1));
        chk("almost", almost_done,  (m_phase == 1) && (m_rem < 4));
        chk("dfsm",   done_FSM,     m_dfsm);
        chk("dcnt",   done_counter, m_dcnt);
        chk("err",    o_err,        m_err);
        chk("count",  o_count,      m_rem);
    endtask

    task automatic idle_cyc();
        cyc(0, 0, 2'd0, 8'd0, 0, 0);
    endtask

    // Accept a run, then idle until done_FSM (bounded), optionally injecting
    // one event when o_count reaches evt_at. lat = edges after accept, -1 if none.
    task automatic timed_run(input logic [1:0] md, input logic [7:0] cl, input int evt,
                             input int evt_at, output int lat, output int busy_n,
                             output int alm_n, output int err_n, output int acc_dcnt);
        int pz_left, k;
        bit fired, stop, st, ab, r, pz;
        logic [1:0] m2;
        lat = -1; busy_n = 0; alm_n = 0; err_n = 0;
        fired = 0; stop = 0; pz_left = 0; k = 0;
        cyc(0, 1, md, cl, 0, 0);
        acc_dcnt = done_counter;
        busy_n += o_busy; alm_n += almost_done; err_n += o_err;
        while (!stop && k < 300) begin
            k++;
            st = 0; ab = 0; r = 0; pz = 0; m2 = md;
            if (!fired && evt != EV_NONE && o_busy && int'(o_count) == evt_at) begin
                fired = 1;
                case (evt)
                    EV_START: begin st = 1; m2 = 2'd0; end
                    EV_ABORT: ab = 1;
                    EV_RST:   r = 1;
                    default:  pz_left = 7;
                endcase
            end
            if (pz_left > 0) begin pz = 1; pz_left--; end
            cyc(r, st, m2, cl, ab, pz);
            busy_n += o_busy; alm_n += almost_done; err_n += o_err;
            if (done_FSM) begin lat = k; stop = 1; end
            if (ab || r) begin
                chk("evt_busy",   o_busy,       0);
                chk("evt_count",  o_count,      0);
                chk("evt_dcnt",   done_counter, 0);
                chk("evt_dfsm",   done_FSM,     0);
                chk("evt_almost", almost_done,  0);
                stop = 1;
            end
        end
    endtask

    initial begin
        int lat, bn, an, en, ad;
        cyc(1, 0, 2'd0, 8'd0, 0, 0);
        cyc(1, 1, 2'd1, 8'd5, 0, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_count", o_count, 0);
        chk("rst_dcnt", done_counter, 0);

        // SHORT run, start one cycle after reset release
        idle_cyc();
        timed_run(2'd0, 8'd0, EV_NONE, 0, lat, bn, an, en, ad);
        chk("short_lat", lat, 16);
        chk("short_busy", bn, 16);
        chk("short_almost", an, 4);
        chk("short_err", en, 0);
        idle_cyc();
        chk("short_sticky", done_counter, 1);

        // LONG run with an ignored SHORT start at count 10
        timed_run(2'd1, 8'd0, EV_START, 10, lat, bn, an, en, ad);
        chk("long_lat", lat, 64);
        chk("long_err", en, 0);
        chk("long_acc_dcnt", ad, 0);

        // CUSTOM lengths 1 and 0
        timed_run(2'd2, 8'd1, EV_NONE, 0, lat, bn, an, en, ad);
        chk("cust1_lat", lat, 1);
        chk("cust1_almost", an, 1);
        chk("cust1_acc_dcnt", ad, 0);
        timed_run(2'd2, 8'd0, EV_NONE, 0, lat, bn, an, en, ad);
        chk("cust0_lat", lat, 1);
        chk("cust0_almost", an, 1);
        chk("cust0_acc_dcnt", ad, 0);

        // Abort at count 20, then start+abort together in IDLE
        timed_run(2'd1, 8'd0, EV_ABORT, 20, lat, bn, an, en, ad);
        chk("abort_lat", lat, -1);
        cyc(0, 1, 2'd0, 8'd0, 1, 0);
        chk("startabort_busy", o_busy, 0);
        idle_cyc();
        chk("startabort_busy2", o_busy, 0);

        // Reserved mode
        cyc(0, 1, 2'd3, 8'd0, 0, 0);
        chk("rsvd_err", o_err, 1);
        chk("rsvd_busy", o_busy, 0);
        idle_cyc();
        chk("rsvd_err_pulse", o_err, 0);

        // Reset mid-run at count 5
        timed_run(2'd0, 8'd0, EV_RST, 5, lat, bn, an, en, ad);
        chk("rst_run_lat", lat, -1);

`ifdef MULTI_MODE_TIMER_PAUSE_EN
        // Pause 7 cycles at count 8
        timed_run(2'd0, 8'd0, EV_PAUSE, 8, lat, bn, an, en, ad);
        chk("pause_lat", lat, 23);
`endif

        // Randomized phase
        for (int i = 0; i < 2500; i++) begin
            bit r, st, ab, pz;
            logic [1:0] md;
            logic [7:0] cl;
            r  = ($urandom_range(0, 99) == 0);
            st = ($urandom_range(0, 3) == 0);
            ab = ($urandom_range(0, 19) == 0);
            pz = ($urandom_range(0, 3) == 0);
            md = 2'($urandom_range(0, 3));
            cl = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(0, 40));
            cyc(r, st, md, cl, ab, pz);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
